// File: rtl/count_monitor.sv
// Passive checker for the up/down counter: predicts each sample, locks onto the sequence, and reports mismatches and wraps.
// Define COUNT_MONITOR_PRED_EN to expose the registered prediction on o_pred.
module count_monitor #(
    parameter int COUNT_WD = 8,
    parameter int ERR_WD   = 8,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic                i_clk,
    input  logic                i_rstb,
    input  logic [COUNT_WD-1:0] i_count,
    input  logic                i_tm_direction,
    input  logic                i_tm_reset,
    input  logic                i_clr_err,
`ifdef COUNT_MONITOR_PRED_EN
    output logic [COUNT_WD-1:0] o_pred,
`endif
    output logic                o_locked,
    output logic                o_mismatch,
    output logic                o_wrap,
    output logic [ERR_WD-1:0]   o_err_cnt,
    output logic                o_err_sticky
);

    typedef enum logic [1:0] {
        ST_ACQ,
        ST_VERIFY,
        ST_TRACK
    } state_t;

    localparam logic [COUNT_WD-1:0] CNT_MAX   = '1;
    localparam logic [ERR_WD-1:0]   ERR_MAX   = '1;
    localparam logic [3:0]          LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0]          LOSS_LAST = 4'(LOSS_CNT - 1);

    state_t                state_q, state_d;
    logic [COUNT_WD-1:0]   prev_q;
    logic [COUNT_WD-1:0]   pred_q, pred_d;
    logic                  dir_q;
    logic                  trst_q;
    logic [3:0]            good_q, good_d;
    logic [3:0]            miss_q, miss_d;
    logic                  locked_q, locked_d;
    logic                  mismatch_q, mismatch_d;
    logic                  wrap_q, wrap_d;
    logic [ERR_WD-1:0]     err_q, err_d;
    logic                  sticky_q, sticky_d;

    logic                  match;
    logic                  wrap_seen;

    // Prediction for the next sample is formed now and registered, so pred_q
    // always belongs to the sample currently on i_count.
    assign pred_d = i_tm_reset     ? '0 :
                    i_tm_direction ? i_count - COUNT_WD'(1) :
                                     i_count + COUNT_WD'(1);

    assign match = (i_count == pred_q);

    // A counter clear landing on zero is not a wrap even if prev was max.
    assign wrap_seen = !trst_q &&
                       ((!dir_q && (prev_q == CNT_MAX) && (i_count == '0)) ||
                        ( dir_q && (prev_q == '0)      && (i_count == CNT_MAX)));

    // NOTE: every variable assigned below gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        miss_d     = miss_q;
        locked_d   = locked_q;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        err_d      = err_q;
        sticky_d   = sticky_q;

        if (i_clr_err) begin
            err_d    = '0;
            sticky_d = 1'b0;
        end

        unique case (state_q)
            ST_ACQ: begin
                good_d   = '0;
                miss_d   = '0;
                locked_d = 1'b0;
                state_d  = ST_VERIFY;
            end

            ST_VERIFY: begin
                if (match) begin
                    if (good_q == LOCK_LAST) begin
                        good_d   = '0;
                        locked_d = 1'b1;
                        state_d  = ST_TRACK;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end else begin
                    good_d = '0;
                end
            end

            ST_TRACK: begin
                if (match) begin
                    miss_d = '0;
                    wrap_d = wrap_seen;
                end else begin
                    // A fresh error outranks a coincident clear.
                    mismatch_d = 1'b1;
                    sticky_d   = 1'b1;
                    if (i_clr_err) begin
                        err_d = ERR_WD'(1);
                    end else if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_WD'(1);
                    end
                    if (miss_q == LOSS_LAST) begin
                        miss_d   = '0;
                        locked_d = 1'b0;
                        state_d  = ST_ACQ;
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_ACQ;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q    <= ST_ACQ;
            prev_q     <= '0;
            pred_q     <= '0;
            dir_q      <= 1'b0;
            trst_q     <= 1'b0;
            good_q     <= '0;
            miss_q     <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= i_count;
            pred_q     <= pred_d;
            dir_q      <= i_tm_direction;
            trst_q     <= i_tm_reset;
            good_q     <= good_d;
            miss_q     <= miss_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
        end
    end

    assign o_locked     = locked_q;
    assign o_mismatch   = mismatch_q;
    assign o_wrap       = wrap_q;
    assign o_err_cnt    = err_q;
    assign o_err_sticky = sticky_q;

`ifdef COUNT_MONITOR_PRED_EN
    assign o_pred = pred_q;
`else
    // Prediction stays internal in the default build.
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a default instance plus an ERR_WD=2 instance sharing all stimulus.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rstb;
    logic [7:0] count;
    logic       tm_dir;
    logic       tm_rst;
    logic       clr_err;

    logic       locked, mismatch, wrap, sticky;
    logic [7:0] err_cnt;
    logic       locked2, mismatch2, wrap2, sticky2;
    logic [1:0] err2;
`ifdef COUNT_MONITOR_PRED_EN
    logic [7:0] pred, pred2;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         mm_seen;
    int         wrap_seen;
    logic [7:0] cnt;
    logic [7:0] bad;
    int         exp2 [5] = '{1, 2, 3, 3, 1};

    always #5 clk = ~clk;

    count_monitor #(.COUNT_WD(8), .ERR_WD(8), .LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .i_clk          (clk),
        .i_rstb         (rstb),
        .i_count        (count),
        .i_tm_direction (tm_dir),
        .i_tm_reset     (tm_rst),
        .i_clr_err      (clr_err),
`ifdef COUNT_MONITOR_PRED_EN
        .o_pred         (pred),
`endif
        .o_locked       (locked),
        .o_mismatch     (mismatch),
        .o_wrap         (wrap),
        .o_err_cnt      (err_cnt),
        .o_err_sticky   (sticky)
    );

    count_monitor #(.COUNT_WD(8), .ERR_WD(2), .LOCK_CNT(4), .LOSS_CNT(3)) dut2 (
        .i_clk          (clk),
        .i_rstb         (rstb),
        .i_count        (count),
        .i_tm_direction (tm_dir),
        .i_tm_reset     (tm_rst),
        .i_clr_err      (clr_err),
`ifdef COUNT_MONITOR_PRED_EN
        .o_pred         (pred2),
`endif
        .o_locked       (locked2),
        .o_mismatch     (mismatch2),
        .o_wrap         (wrap2),
        .o_err_cnt      (err2),
        .o_err_sticky   (sticky2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one sample, clock it in, and look at the registered result 1 ns later.
    task automatic drive(input logic [7:0] c, input logic d, input logic r, input logic clr);
        count   = c;
        tm_dir  = d;
        tm_rst  = r;
        clr_err = clr;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        if (mismatch) mm_seen++;
        if (wrap) wrap_seen++;
    endtask

    // Bench-side model of the counter: sample the current value, then advance it.
    task automatic step_ctr(input logic d, input logic r);
        drive(cnt, d, r, 1'b0);
        cnt = r ? 8'h00 : (d ? cnt - 8'h01 : cnt + 8'h01);
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        #2;
        check("rst_locked",   locked,   1'b0);
        check("rst_mismatch", mismatch, 1'b0);
        check("rst_wrap",     wrap,     1'b0);
        check("rst_err",      err_cnt,  8'h00);
        check("rst_sticky",   sticky,   1'b0);
        check("rst_err2",     err2,     2'b00);
        #2;
        rstb = 1'b1;
        cnt  = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstb = 1'b0; count = '0; tm_dir = 1'b0; tm_rst = 1'b0; clr_err = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: count up from reset, lock after the acquire edge plus four good steps.
        mm_seen = 0; wrap_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step_ctr(1'b0, 1'b0);
            if (i == 3) check("t1_not_yet_locked", locked, 1'b0);
            if (i == 4) check("t1_locked", locked, 1'b1);
        end
        check("t1_no_mismatch", mm_seen, 0);
        check("t1_err_zero", err_cnt, 8'h00);
        check("t1_wraps", wrap_seen, 3);

        // 2: single up-wrap, pulse visible right after 0 is sampled.
        mm_seen = 0;
        while (cnt != 8'hFF) step_ctr(1'b0, 1'b0);
        step_ctr(1'b0, 1'b0);
        check("t2_no_wrap_at_ff", wrap, 1'b0);
        step_ctr(1'b0, 1'b0);
        check("t2_wrap_at_0", wrap, 1'b1);
        step_ctr(1'b0, 1'b0);
        check("t2_wrap_one_cycle", wrap, 1'b0);
        check("t2_no_mismatch", mm_seen, 0);

        // 3: clear at 0x37, then count down through a down-wrap.
        while (cnt != 8'h37) step_ctr(1'b0, 1'b0);
        mm_seen = 0;
        step_ctr(1'b0, 1'b1);
        step_ctr(1'b1, 1'b0);
        check("t3_clear_not_wrap", wrap, 1'b0);
        check("t3_zero_accepted", mismatch, 1'b0);
        step_ctr(1'b1, 1'b0);
        check("t3_down_wrap", wrap, 1'b1);
        check("t3_no_mismatch", mm_seen, 0);

        // 4: single glitch while locked, then resync on the glitched value.
        while (cnt != 8'h42) step_ctr(1'b0, 1'b0);
        check("t4_clean_approach", mm_seen, 0);
        drive(8'h10, 1'b0, 1'b0, 1'b0);
        check("t4_mismatch", mismatch, 1'b1);
        check("t4_err", err_cnt, 8'h01);
        check("t4_sticky", sticky, 1'b1);
        check("t4_still_locked", locked, 1'b1);
        cnt = 8'h11;
        step_ctr(1'b0, 1'b0);
        check("t4_resync_11", mismatch, 1'b0);
        step_ctr(1'b0, 1'b0);
        check("t4_resync_12", mismatch, 1'b0);
        check("t4_err_hold", err_cnt, 8'h01);

        // 5: clear errors, lose lock on three misses, relock; VERIFY misses are silent.
        drive(cnt, 1'b0, 1'b0, 1'b1);
        cnt = cnt + 8'h01;
        check("t5_clr_err", err_cnt, 8'h00);
        check("t5_clr_sticky", sticky, 1'b0);
        drive(8'hA0, 1'b0, 1'b0, 1'b0);
        check("t5_miss1_locked", locked, 1'b1);
        drive(8'h55, 1'b0, 1'b0, 1'b0);
        check("t5_miss2_err", err_cnt, 8'h02);
        drive(8'hC3, 1'b0, 1'b0, 1'b0);
        check("t5_miss3_err", err_cnt, 8'h03);
        check("t5_lock_lost", locked, 1'b0);
        drive(8'h50, 1'b0, 1'b0, 1'b0);
        drive(8'h51, 1'b0, 1'b0, 1'b0);
        drive(8'h52, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        check("t5_verify_silent", mismatch, 1'b0);
        check("t5_verify_err_hold", err_cnt, 8'h03);
        cnt = 8'h01;
        for (int i = 0; i < 4; i++) begin
            step_ctr(1'b0, 1'b0);
            if (i == 2) check("t5_relock_pending", locked, 1'b0);
        end
        check("t5_relocked", locked, 1'b1);
        check("t5_err_final", err_cnt, 8'h03);

        // 6: async reset while locked, then saturation of the 2-bit counter and clear-vs-error.
        do_reset();
        for (int i = 0; i < 5; i++) step_ctr(1'b0, 1'b0);
        check("t6_locked", locked2, 1'b1);
        for (int k = 0; k < 5; k++) begin
            bad = cnt + 8'h40;
            drive(bad, 1'b0, 1'b0, k == 4);
            check($sformatf("t6_err2_%0d", k + 1), err2, exp2[k]);
            check($sformatf("t6_mismatch_%0d", k + 1), mismatch2, 1'b1);
            if (k < 4) begin
                cnt = bad + 8'h01;
                step_ctr(1'b0, 1'b0);
                check($sformatf("t6_good_%0d", k + 1), mismatch2, 1'b0);
            end
        end
        check("t6_sticky2", sticky2, 1'b1);
        check("t6_err8_after_clr", err_cnt, 8'h01);
        check("t6_still_locked", locked2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Passive receiver-side checker for the up/down `counter` block.
- Samples the counter's `o_count` output each cycle, along with copies of the counter's `i_tm_direction` and `i_tm_reset` controls.
- Predicts the next value, acquires lock, and flags mismatches, wrap events and loss of lock.
- Sits beside the counter in the demo environment and in system-level self-checking benches; can also be instantiated in silicon as a built-in monitor.

Parameters:
- COUNT_WD, 8: width of monitored count, in bits.
- ERR_WD, 8: width of the saturating error counter.
- LOCK_CNT, 4: consecutive correct steps required to declare lock (range 1..15).
- LOSS_CNT, 3: consecutive mismatches while locked that drop lock (range 1..15).

Ports:
- i_clk  in  1  clock; all sampling on rising edge.
- i_rstb  in  1  asynchronous active-low reset.
- i_count  in  COUNT_WD  observed counter value.
- i_tm_direction  in  1  copy of the counter direction control (0 = increment, 1 = decrement).
- i_tm_reset  in  1  copy of the counter synchronous clear.
- i_clr_err  in  1  synchronous clear of o_err_cnt and o_err_sticky.
- o_locked  out  1  monitor is locked to the count sequence.
- o_mismatch  out  1  one-cycle pulse: a locked sample differed from prediction.
- o_wrap  out  1  one-cycle pulse: a legal wrap was observed.
- o_err_cnt  out  ERR_WD  saturating mismatch count.
- o_err_sticky  out  1  set on the first mismatch; held until i_clr_err or reset.

Behaviour:
- Reset values: all outputs 0; state ACQ; internal prev/pred/direction/flag registers 0.
- Prediction for the sample at cycle n, using registered values from cycle n-1:
  - i_tm_reset=1 at n-1: pred = 0.
  - Otherwise: pred = prev + 1 when dir=0, prev - 1 when dir=1, both modulo 2^COUNT_WD.
  - prev = i_count at n-1.
- States:
  - ACQ: capture i_count into prev; go to VERIFY. o_locked=0.
  - VERIFY: each match increments good_cnt. When good_cnt reaches LOCK_CNT, go to TRACK and set o_locked (registered, visible the following cycle). Any mismatch clears good_cnt and stays in VERIFY. Mismatches here are not reported or counted.
  - TRACK: o_locked=1. A mismatch pulses o_mismatch, increments o_err_cnt (saturating at all-ones, never wraps) and sets o_err_sticky. LOSS_CNT consecutive mismatches go to ACQ and clear o_locked. Any match resets the consecutive-miss counter.
- prev is updated with the actual i_count every cycle, in every state, so tracking resynchronises after a single glitch.
- Latency: o_mismatch and o_wrap are asserted on the cycle after the offending or wrapping sample is clocked in.
- o_wrap, TRACK only, only on a matching sample:
  - prev = max and sample = 0 with dir=0; or
  - prev = 0 and sample = max with dir=1.
  - A clear to 0 via i_tm_reset is never a wrap.
- Simultaneous events:
  - i_clr_err and a mismatch in the same cycle: o_err_cnt = 1 and sticky = 1 (the new error wins over the clear).
  - i_tm_reset together with a direction change: the reset takes priority in prediction.
- Asynchronous reset mid-operation: immediate return to reset values; re-acquisition restarts from ACQ.

Optional Feature:
- Macro: COUNT_MONITOR_PRED_EN.
- When defined: adds output port o_pred (COUNT_WD bits) exposing the registered prediction for the current cycle's sample, for waveform debug; reset value 0.
- When undefined: port absent; prediction logic is otherwise identical.

Test Plan:
1. Reset, then count up 0,1,2,...,1000 cycles -> o_locked=1 by cycle 6 after reset; o_mismatch never asserted; o_err_cnt=0.
2. Locked, counting up through 255 -> 0 -> one o_wrap pulse per wrap, on the cycle after 0 is sampled; no mismatch.
3. i_tm_reset pulse at count 0x37, then direction=1 -> next sample 0 accepted; then 0xFF accepted as a down-wrap (o_wrap=1); no mismatch.
4. Locked, inject one corrupt sample 0x10 where 0x42 is predicted -> one o_mismatch pulse; o_err_cnt=1; sticky=1; o_locked stays 1; the following samples 0x11, 0x12 are accepted.
5. Locked, three consecutive bad samples -> o_err_cnt=3; o_locked drops; relock after LOCK_CNT (4) good steps; a mismatch during VERIFY leaves o_err_cnt unchanged.
6. ERR_WD=2, force 5 mismatches, with i_clr_err asserted coincident with the 5th -> o_err_cnt saturates at 3, then reads 1 after the clear; sticky remains 1.
